// File: rtl/wishbone_arbiter2.sv
// rtl/wishbone_arbiter2.sv - two-master round-robin Wishbone arbiter with slave-ack watchdog
//
// Shares one Wishbone slave segment between master 0 (instruction port) and
// master 1 (data port). Each granted request is registered onto the slave
// side. The response goes back only to the master that owns the bus.
//
// Ports:
//   clk, rst                     clock, asynchronous active-low reset
//   m0_*/m1_* cyc,stb,we,sel,
//     addr,data_i                master requests
//   m0_*/m1_* data_o,ack_o,err_o master responses (one-cycle ack/err)
//   s_cyc_o..s_data_o            registered slave request
//   s_data_i, s_ack_i            slave response
//   grant_o                      debug one-hot owner, 0 when idle
module wishbone_arbiter2 #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        grant_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       owner;
  logic       last;
  logic [7:0] wd;
  logic       req0, req1;
  logic       grant_any;
  logic       pick;
  logic       own_cyc;
  logic       wd_exp;

  // A master acked this cycle is masked so its finished transfer is not re-granted.
  assign req0    = m0_cyc_i & m0_stb_i & ~m0_ack_o;
  assign req1    = m1_cyc_i & m1_stb_i & ~m1_ack_o;
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign wd_exp  = (wd == WD_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_any = 1'b0;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        grant_any = req0 | req1;
        // On a tie the master that did not win last time gets the bus.
        pick      = (req0 & req1) ? ~last : req1;
        if (grant_any) state_nxt = BUSY;
      end
      BUSY: begin
        if (s_ack_i || !own_cyc || wd_exp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= 1'b0;
      last      <= 1'b1;
      wd        <= 8'd0;
      m0_data_o <= '0;
      m1_data_o <= '0;
      m0_ack_o  <= 1'b0;
      m1_ack_o  <= 1'b0;
      m0_err_o  <= 1'b0;
      m1_err_o  <= 1'b0;
      s_cyc_o   <= 1'b0;
      s_stb_o   <= 1'b0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_addr_o  <= '0;
      s_data_o  <= '0;
      grant_o   <= 2'b00;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      if (state == IDLE) begin
        if (grant_any) begin
          owner    <= pick;
          last     <= pick;
          s_addr_o <= pick ? m1_addr_i : m0_addr_i;
          s_data_o <= pick ? m1_data_i : m0_data_i;
          s_we_o   <= pick ? m1_we_i   : m0_we_i;
          s_sel_o  <= pick ? m1_sel_i  : m0_sel_i;
          s_cyc_o  <= 1'b1;
          s_stb_o  <= 1'b1;
          wd       <= 8'd0;
          grant_o  <= pick ? 2'b10 : 2'b01;
        end
      end else begin
        wd <= wd + 8'd1;
        if (s_ack_i) begin
          if (!s_we_o) begin
            if (owner) m1_data_o <= s_data_i;
            else       m0_data_o <= s_data_i;
          end
          if (owner) m1_ack_o <= 1'b1;
          else       m0_ack_o <= 1'b1;
          s_cyc_o <= 1'b0;
          s_stb_o <= 1'b0;
          grant_o <= 2'b00;
        end else if (!own_cyc) begin
          s_cyc_o <= 1'b0;
          s_stb_o <= 1'b0;
          grant_o <= 2'b00;
        end else if (wd_exp) begin
          // Watchdog: error ack with zeroed read data so the master cannot hang.
          if (owner) begin
            m1_ack_o  <= 1'b1;
            m1_err_o  <= 1'b1;
            m1_data_o <= '0;
          end else begin
            m0_ack_o  <= 1'b1;
            m0_err_o  <= 1'b1;
            m0_data_o <= '0;
          end
          s_cyc_o <= 1'b0;
          s_stb_o <= 1'b0;
          grant_o <= 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// tb/tb_wishbone_arbiter2.sv - self-checking bench for wishbone_arbiter2
module tb_wishbone_arbiter2;

  logic        clk, rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_addr_o, s_data_o, s_data_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  int checks = 0;
  int failures = 0;

  // Slave model: acks ack_wait cycles after the strobe appears (0 = zero-wait).
  logic slave_en;
  int   ack_wait;
  int   wcnt;
  assign s_ack_i = slave_en & s_cyc_o & s_stb_o & (wcnt == ack_wait);

  always @(posedge clk) begin
    if (s_cyc_o && !s_ack_i) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  wishbone_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mst;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_c;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic m, input logic on, input logic we, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] d);
    if (!m) begin
      m0_cyc_i = on; m0_stb_i = on; m0_we_i = we; m0_sel_i = sel;
      m0_addr_i = a; m0_data_i = d;
    end else begin
      m1_cyc_i = on; m1_stb_i = on; m1_we_i = we; m1_sel_i = sel;
      m1_addr_i = a; m1_data_i = d;
    end
  endtask

  function automatic logic own_ack(input logic m);
    return m ? m1_ack_o : m0_ack_o;
  endfunction

  function automatic logic other_ack(input logic m);
    return m ? m0_ack_o : m1_ack_o;
  endfunction

  task automatic run_vec(input vec_t v);
    int          lat;
    logic        seen, stable_ok, wrong, err;
    logic [31:0] dat;
    logic        scyc_at_ack;
    lat = 0; seen = 0; stable_ok = 1; wrong = 0; err = 0; dat = '0; scyc_at_ack = 1;
    slave_en = 1'b1; ack_wait = v.wait_c; s_data_i = v.rdata;
    drive(v.mst, 1'b1, v.we, v.sel, v.addr, v.wdata);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (s_cyc_o) begin
        if (s_addr_o !== v.addr || s_data_o !== v.wdata || s_sel_o !== v.sel ||
            s_we_o !== v.we || s_stb_o !== 1'b1 || grant_o !== (v.mst ? 2'b10 : 2'b01))
          stable_ok = 0;
      end
      if (other_ack(v.mst)) wrong = 1;
      if (own_ack(v.mst)) begin
        seen = 1; lat = c;
        err = v.mst ? m1_err_o : m0_err_o;
        dat = v.mst ? m1_data_o : m0_data_o;
        scyc_at_ack = s_cyc_o;
      end
    end
    drive(v.mst, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("xfer_latency", 64'(lat), 64'(v.exp_lat));
    chk("xfer_err", 64'(err), 64'd0);
    chk("xfer_data", 64'(dat), 64'(v.exp_data));
    chk("xfer_slave_stable", 64'(stable_ok), 64'd1);
    chk("xfer_wrong_master", 64'(wrong), 64'd0);
    chk("xfer_scyc_dropped", 64'(scyc_at_ack), 64'd0);
    @(negedge clk);
    chk("xfer_single_pulse", 64'(own_ack(v.mst)), 64'd0);
  endtask

  initial begin
    vec_t        vx;
    int          lat, ngr, wrong, dbl, acks;
    logic [1:0]  prev_grant;
    logic        prev_a0, prev_a1, seen;
    logic [1:0]  gq[8];

    vt[0] = '{1'b0, 1'b0, 4'hF, 32'h8000_0010, 32'h0000_0000, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3};
    vt[1] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'h1234_5678, 0, 32'hAAAA_5555, 32'h0000_0000, 2};
    vt[2] = '{1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0000_0000, 2, 32'hCAFE_0001, 32'hCAFE_0001, 4};
    vt[3] = '{1'b0, 1'b1, 4'hF, 32'h0000_0010, 32'h0000_0011, 0, 32'h0000_0099, 32'hDEAD_BEEF, 2};
    vt[4] = '{1'b1, 1'b1, 4'h8, 32'h0000_0200, 32'hFFFF_0000, 3, 32'h1111_2222, 32'hCAFE_0001, 5};
    // Ack lands on the same edge the watchdog would expire (TIMEOUT=8): normal ack wins.
    vt[5] = '{1'b0, 1'b0, 4'hF, 32'h0000_0080, 32'h0000_0000, 7, 32'h0BAD_F00D, 32'h0BAD_F00D, 9};

    rst = 1'b0; slave_en = 1'b0; ack_wait = 0; s_data_i = '0;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk);
    chk("rst_slave_ctl", 64'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 64'd0);
    chk("rst_slave_addr_data", {s_addr_o, s_data_o}, 64'd0);
    chk("rst_master_resp", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, grant_o}), 64'd0);
    chk("rst_master_data", {m0_data_o, m1_data_o}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // Timeout: slave never answers.
    slave_en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    lat = 0; seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (m0_ack_o) begin
        seen = 1; lat = c;
        chk("to_err", 64'(m0_err_o), 64'd1);
        chk("to_data_zero", 64'(m0_data_o), 64'd0);
        chk("to_scyc", 64'(s_cyc_o), 64'd0);
        chk("to_m1_quiet", 64'({m1_ack_o, m1_err_o}), 64'd0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("to_latency", 64'(lat), 64'd9);
    @(negedge clk);
    chk("to_single_pulse", 64'({m0_ack_o, m0_err_o}), 64'd0);
    vx = '{1'b1, 1'b0, 4'hF, 32'h0000_0044, 32'h0, 0, 32'h5A5A_0001, 32'h5A5A_0001, 2};
    run_vec(vx);

    // Round-robin: both request continuously, zero-wait slave.
    slave_en = 1'b1; ack_wait = 0; s_data_i = 32'h7777_0000;
    drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0030, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0034, 32'h0);
    ngr = 0; wrong = 0; dbl = 0; prev_grant = 2'b00; prev_a0 = 0; prev_a1 = 0;
    for (int c = 0; c < 60 && ngr < 8; c++) begin
      @(negedge clk);
      if (grant_o != 2'b00 && prev_grant == 2'b00) begin
        gq[ngr] = grant_o;
        ngr++;
      end
      if (m0_ack_o && prev_grant != 2'b01) wrong++;
      if (m1_ack_o && prev_grant != 2'b10) wrong++;
      if ((m0_ack_o && prev_a0) || (m1_ack_o && prev_a1)) dbl++;
      prev_grant = grant_o; prev_a0 = m0_ack_o; prev_a1 = m1_ack_o;
    end
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rr_grant_count", 64'(ngr), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rr_grant_%0d", i), 64'(gq[i]), ((i % 2) == 0) ? 64'd1 : 64'd2);
    chk("rr_wrong_master", 64'(wrong), 64'd0);
    chk("rr_double_ack", 64'(dbl), 64'd0);
    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("rr_m0_data", 64'(m0_data_o), 64'h7777_0000);

    // Abort: m1 drops cyc while BUSY.
    slave_en = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (s_cyc_o) seen = 1;
    end
    chk("abort_granted", 64'(grant_o), 64'd2);
    m1_cyc_i = 1'b0;
    @(negedge clk);
    chk("abort_slave_drop", 64'({s_cyc_o, s_stb_o}), 64'd0);
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      if (m0_ack_o || m1_ack_o || m1_err_o) acks++;
      @(negedge clk);
    end
    m1_stb_i = 1'b0;
    chk("abort_no_ack", 64'(acks), 64'd0);
    chk("abort_idle", 64'(grant_o), 64'd0);

    // Reset mid-transfer with an ack pending.
    slave_en = 1'b1; ack_wait = 3; s_data_i = 32'h3333_4444;
    drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0060, 32'h0);
    @(negedge clk); @(negedge clk);
    chk("rmid_busy", 64'(s_cyc_o), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rmid_async_slave", 64'({s_cyc_o, s_stb_o, grant_o}), 64'd0);
    chk("rmid_async_addr", 64'(s_addr_o), 64'd0);
    chk("rmid_async_data", 64'(m0_data_o), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (m0_ack_o || m1_ack_o) acks++;
    end
    chk("rmid_no_ack", 64'(acks), 64'd0);
    ack_wait = 0;
    drive(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0070, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0074, 32'h0);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (grant_o != 2'b00) seen = 1;
    end
    chk("rmid_first_tie_m0", 64'(grant_o), 64'd1);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int c = 0; c < 4; c++) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wishbone_arbiter2.md
# wishbone_arbiter2

Two-master, one-slave Wishbone arbiter that shares the single bus segment in front of `bus_top` between the CPU instruction port (master 0) and the CPU data port (master 1). It grants the bus by round-robin and registers each granted request onto the slave side. It returns the slave's data and acknowledge to the owning master only. A watchdog returns an error acknowledge to the owning master if the slave never acks, so a missing peripheral cannot hang the pipeline.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, slave-ack watchdog limit in cycles; legal range 1..255; counter is 8 bits

Ports (x = 0 or 1):
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `mx_cyc_i`  in  1  master x cycle valid
- `mx_stb_i`  in  1  master x strobe
- `mx_we_i`  in  1  master x write enable
- `mx_sel_i`  in  4  master x byte selects
- `mx_addr_i`  in  ADDR_W  master x address
- `mx_data_i`  in  DATA_W  master x write data
- `mx_data_o`  out  DATA_W  read data to master x
- `mx_ack_o`  out  1  one-cycle acknowledge to master x
- `mx_err_o`  out  1  one-cycle timeout error, coincident with `mx_ack_o`
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  slave control
- `s_sel_o`  out  4  slave byte selects
- `s_addr_o`  out  ADDR_W  slave address
- `s_data_o`  out  DATA_W  slave write data
- `s_data_i`  in  DATA_W  slave read data
- `s_ack_i`  in  1  slave acknowledge
- `grant_o`  out  2  debug: bit0 = master 0 owns the bus, bit1 = master 1 owns it; both 0 in IDLE

## Operation
- Request: `mx_req = mx_cyc_i & mx_stb_i & ~mx_ack_o`. A master whose ack is high in the current cycle is masked, so a just-finished transfer is not re-granted.
- `last` register holds the index of the last granted master; reset value 1, so master 0 wins the first tie.
- **IDLE**
  - A single request is granted to that master.
  - With two requests, the grant goes to `~last`.
  - On grant: latch owner, set `last` = owner, register the owner's addr, data, we and sel onto the slave outputs, set `s_cyc_o` = `s_stb_o` = 1, clear the watchdog, go to BUSY.
- **BUSY**
  - Slave outputs are held stable.
  - Watchdog counter increments each cycle.
  - `s_ack_i` = 1:
    - read: `m<owner>_data_o` <= `s_data_i`; write: `m<owner>_data_o` keeps its value.
    - `m<owner>_ack_o` <= 1 for one cycle.
    - `s_cyc_o`, `s_stb_o` <= 0; go to IDLE.
  - Otherwise, owner `cyc_i` = 0 (abort): drop the slave strobes, no ack, go to IDLE.
  - Otherwise, watchdog = `TIMEOUT`-1: assert `m<owner>_ack_o` and `m<owner>_err_o` for one cycle, set `m<owner>_data_o` <= 0, drop the slave strobes, go to IDLE.
  - Priority within BUSY: ack > abort > timeout.
- The non-owner never sees ack or err. Its request waits, with signals held, until IDLE.
- `mx_data_o` holds its last value between acks.
- Reset mid-transfer (`rst` low): every output goes to 0 immediately, state to IDLE, `last` to 1. A pending ack is lost.

## Timing
- Reset values:
  - all `mx_ack_o`, `mx_err_o`, `mx_data_o` = 0
  - all slave outputs = 0
  - `grant_o` = 0, state IDLE, watchdog 0
- Request sampled in IDLE at edge N; the slave strobe is visible after edge N.
- Slave ack at edge N+k (k >= 1); master ack visible after edge N+k, for exactly one cycle.
- Single transfer latency = k+1 cycles. At least one IDLE cycle separates consecutive grants.
- Both masters continuously requesting, zero-wait slave (k = 1): grants alternate 0,1,0,1; each master completes one transfer per 4 cycles.
- Timeout: error ack is visible `TIMEOUT`+1 cycles after the grant edge.
- `grant_o` is high from the grant edge until the edge that leaves BUSY.

## Test plan
- Reset/first access: hold `rst`=0, check all outputs 0. Release; m0 reads `0x8000_0010`; slave acks after 2 cycles with `0xDEAD_BEEF` -> `s_addr_o`=`0x8000_0010`, `s_we_o`=0, `m0_ack_o` pulses 1 cycle, `m0_data_o`=`0xDEAD_BEEF`, `m1_ack_o` stays 0.
- Round-robin: m0 and m1 request continuously, zero-wait slave, 8 transfers -> grant order 0,1,0,1,0,1,0,1; no double ack; no ack to the wrong master.
- Write path: m1 writes `0x1234_5678`, sel `4'b0011`, addr `0x0000_0100` -> slave sees exactly these values for the whole BUSY period; `m1_ack_o` pulses once; `m1_data_o` unchanged.
- Timeout: `TIMEOUT`=8, slave never acks, m0 reads -> `m0_ack_o`=`m0_err_o`=1 for one cycle, 9 cycles after grant; `m0_data_o`=0; `s_cyc_o`=0; the next m1 request is granted normally.
- Abort and ack priority:
  - m1 drops `cyc_i` in BUSY -> `s_cyc_o` falls after 1 edge, no ack.
  - Ack arriving on the same cycle as the timeout expiry -> normal ack with `err`=0.
- Reset mid-transfer: assert `rst` low while BUSY with slave ack pending -> outputs 0 asynchronously, with no ack after release; m0 then wins the first tie.
